// File: rtl/pic_8259_pkg.sv
// ----------------------------------------------------------------------------
// Package: pic_8259_pkg
//
// Purpose
//   Shared constants and helper functions for the 8259A interrupt controller
//   slice. Used by the interrupt request stage, its priority resolver and the
//   in-service stage.
//
// Contents
//   IRQ_WIDTH      number of IR lines (fixed at 8)
//   PRIO_BITS      width of a priority level / rotate amount (log2 IRQ_WIDTH)
//   rotate_right8  circular right rotate of an 8-bit vector
//   rotate_left8   circular left rotate of an 8-bit vector
//   lowest_one_hot8  isolate the lowest set bit of an 8-bit vector
// ----------------------------------------------------------------------------
package pic_8259_pkg;

  localparam int IRQ_WIDTH = 8;
  localparam int PRIO_BITS = 3;

  // Bit j of the result is data[(j + amount) mod 8], so the bit at position
  // 'amount' ends up at bit 0.
  function automatic logic [7:0] rotate_right8(input logic [7:0] data,
                                               input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {data, data} >> amount;
    return doubled[7:0];
  endfunction

  // Inverse of rotate_right8: bit j of the result is data[(j - amount) mod 8].
  function automatic logic [7:0] rotate_left8(input logic [7:0] data,
                                              input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {data, data} << amount;
    return doubled[15:8];
  endfunction

  // Two's complement trick: data & -data keeps only the lowest set bit.
  // Returns zero when data is zero.
  function automatic logic [7:0] lowest_one_hot8(input logic [7:0] data);
    return data & (~data + 8'd1);
  endfunction

endpackage : pic_8259_pkg

// File: rtl/pic_priority_resolver.sv
// ----------------------------------------------------------------------------
// Module: pic_priority_resolver
//
// Purpose
//   Purely combinational priority resolution for the 8259A. Picks the highest
//   priority pending candidate, honouring fully nested mode: the candidate
//   only wins if it is strictly higher priority than every level currently in
//   service (after special-mask filtering, done by the caller).
//
// Ports
//   cand             in   8  unmasked pending requests (IRR & ~IMR)
//   eff_isr          in   8  in-service levels that block nesting
//   priority_rotate  in   3  lowest priority level; highest is rotate+1 mod 8
//   winner           out  8  one-hot winning level, 0 when nothing qualifies
// ----------------------------------------------------------------------------
module pic_priority_resolver
  import pic_8259_pkg::*;
(
  input  logic [IRQ_WIDTH-1:0] cand,
  input  logic [IRQ_WIDTH-1:0] eff_isr,
  input  logic [PRIO_BITS-1:0] priority_rotate,
  output logic [IRQ_WIDTH-1:0] winner
);

  logic [PRIO_BITS-1:0] shift;
  logic [IRQ_WIDTH-1:0] rot_cand;
  logic [IRQ_WIDTH-1:0] rot_isr;
  logic [IRQ_WIDTH-1:0] win_rot;
  logic [IRQ_WIDTH-1:0] isr_low;
  logic                 accept;

  // The highest priority level is one above the rotate setting; the 3-bit add
  // wraps naturally, so rotate=7 gives a shift of 0 (IR0 highest).
  assign shift = priority_rotate + 3'd1;

  // After rotation, bit 0 is the highest priority level, so "lowest set bit"
  // means "highest priority". Because both winner and ISR level are one-hot
  // in the same rotated frame, a plain numeric compare orders their
  // priorities: smaller value means higher priority.
  always_comb begin
    rot_cand = rotate_right8(cand, shift);
    rot_isr  = rotate_right8(eff_isr, shift);
    win_rot  = lowest_one_hot8(rot_cand);
    isr_low  = lowest_one_hot8(rot_isr);
    accept   = (win_rot != '0) && ((rot_isr == '0) || (win_rot < isr_low));
    winner   = accept ? rotate_left8(win_rot, shift) : '0;
  end

endmodule : pic_priority_resolver

// File: rtl/pic_interrupt_request_stage.sv
// ----------------------------------------------------------------------------
// Module: pic_interrupt_request_stage
//
// Purpose
//   Interrupt Request Register (IRR) stage of the 8259A. Samples the IR7..IR0
//   pins, applies edge or level sensing into the IRR, and registers the
//   highest-priority unmasked request as a one-hot 'interrupt' vector for the
//   control logic. All flops of this stage live here; resolution is done by
//   the combinational pic_priority_resolver.
//
// Configuration
//   IRQ_PIN_SYNC_EN  when defined, a two-flop synchroniser sits in front of
//                    the pin sampling logic (pin-to-interrupt latency +2).
//                    When undefined the pins must already be synchronous.
//
// Ports
//   clock                            in   1  rising-edge clock
//   reset_n                          in   1  asynchronous reset, active-low
//   interrupt_request_pin            in   8  raw IR7..IR0 pins
//   write_initial_command_word_1     in   1  ICW1 strobe: clear IRR, re-arm edges
//   level_or_edge_toriggered_config  in   1  1 = level mode, 0 = edge mode
//   freeze                           in   1  hold IRR against pin activity
//   clear_interrupt_request          in   8  one-cycle per-bit IRR clear
//   interrupt_mask                   in   8  IMR (1 = masked)
//   interrupt_special_mask           in   8  ISR bits ignored for nesting
//   in_service_register              in   8  current ISR contents
//   priority_rotate                  in   3  lowest priority level
//   interrupt_request_register       out  8  registered IRR
//   interrupt                        out  8  registered one-hot winner, 0 = none
// ----------------------------------------------------------------------------
module pic_interrupt_request_stage
  import pic_8259_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IRQ_WIDTH-1:0] interrupt_request_pin,
  input  logic                 write_initial_command_word_1,
  input  logic                 level_or_edge_toriggered_config,
  input  logic                 freeze,
  input  logic [IRQ_WIDTH-1:0] clear_interrupt_request,
  input  logic [IRQ_WIDTH-1:0] interrupt_mask,
  input  logic [IRQ_WIDTH-1:0] interrupt_special_mask,
  input  logic [IRQ_WIDTH-1:0] in_service_register,
  input  logic [PRIO_BITS-1:0] priority_rotate,
  output logic [IRQ_WIDTH-1:0] interrupt_request_register,
  output logic [IRQ_WIDTH-1:0] interrupt
);

  // The rotate/resolve helpers are hard-wired to 8 lines.
  if (IRQ_WIDTH != 8) begin : g_width_check
    $error("pic_interrupt_request_stage supports exactly 8 IR lines");
  end

  logic [IRQ_WIDTH-1:0] pin_s;
  logic [IRQ_WIDTH-1:0] pin_q;
  logic [IRQ_WIDTH-1:0] pin_d;
  logic [IRQ_WIDTH-1:0] irr_q;
  logic [IRQ_WIDTH-1:0] irr_d;
  logic [IRQ_WIDTH-1:0] int_q;
  logic [IRQ_WIDTH-1:0] edge_set;
  logic [IRQ_WIDTH-1:0] cand;
  logic [IRQ_WIDTH-1:0] eff_isr;
  logic [IRQ_WIDTH-1:0] winner;

`ifdef IRQ_PIN_SYNC_EN
  // Two-flop synchroniser for pins that are asynchronous to clock.
  logic [IRQ_WIDTH-1:0] sync1_q;
  logic [IRQ_WIDTH-1:0] sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= interrupt_request_pin;
      sync2_q <= sync1_q;
    end
  end

  assign pin_s = sync2_q;
`else
  assign pin_s = interrupt_request_pin;
`endif

  // Edge history. It resets and re-arms to all-ones so that a pin already
  // high after reset or ICW1 is not mistaken for a fresh rising edge. It
  // keeps tracking during freeze, which is what makes a frozen edge get lost.
  assign pin_d = write_initial_command_word_1 ? '1 : pin_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pin_q <= '1;
    end else begin
      pin_q <= pin_d;
    end
  end

  assign edge_set = pin_s & ~pin_q;

  // IRR next state. ICW1 wins over everything; the per-bit clear always wins
  // over a pin-driven set in the same cycle. Freeze only blocks pin-driven
  // changes (set and withdraw), never the clear from the control logic.
  // In edge mode a low pin withdraws the request; set requires a high pin,
  // so set and withdraw never collide on the same bit.
  always_comb begin
    irr_d = irr_q;
    if (write_initial_command_word_1) begin
      irr_d = '0;
    end else if (freeze) begin
      irr_d = irr_q & ~clear_interrupt_request;
    end else if (level_or_edge_toriggered_config) begin
      irr_d = pin_s & ~clear_interrupt_request;
    end else begin
      irr_d = (irr_q | edge_set) & pin_s & ~clear_interrupt_request;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irr_q <= '0;
    end else begin
      irr_q <= irr_d;
    end
  end

  // Resolution works from the registered IRR so the winner is a clean,
  // glitch-free function of state plus the control-logic configuration.
  assign cand    = irr_q & ~interrupt_mask;
  assign eff_isr = in_service_register & ~interrupt_special_mask;

  pic_priority_resolver u_resolver (
    .cand            (cand),
    .eff_isr         (eff_isr),
    .priority_rotate (priority_rotate),
    .winner          (winner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      int_q <= '0;
    end else begin
      int_q <= winner;
    end
  end

  assign interrupt_request_register = irr_q;
  assign interrupt                  = int_q;

endmodule : pic_interrupt_request_stage

// File: tb/tb_pic_interrupt_request_stage.sv
// ----------------------------------------------------------------------------
// Testbench: tb_pic_interrupt_request_stage
//
// Directed sequence for the IRR stage in its default build (no pin
// synchroniser). Each step drives inputs on the falling edge, pushes the
// expected IRR / interrupt values for the next rising edge onto a scoreboard,
// then pops and compares them on the following falling edge.
// ----------------------------------------------------------------------------
module tb_pic_interrupt_request_stage;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] pin;
  logic       icw1;
  logic       ltim;
  logic       freeze;
  logic [7:0] clr;
  logic [7:0] mask;
  logic [7:0] smask;
  logic [7:0] isr;
  logic [2:0] rot;
  logic [7:0] irr;
  logic [7:0] intr;

  string      tagQ[$];
  logic [7:0] expIrrQ[$];
  logic [7:0] expIntQ[$];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pic_interrupt_request_stage dut (
    .clock                           (clock),
    .reset_n                         (reset_n),
    .interrupt_request_pin           (pin),
    .write_initial_command_word_1    (icw1),
    .level_or_edge_toriggered_config (ltim),
    .freeze                          (freeze),
    .clear_interrupt_request         (clr),
    .interrupt_mask                  (mask),
    .interrupt_special_mask          (smask),
    .in_service_register             (isr),
    .priority_rotate                 (rot),
    .interrupt_request_register      (irr),
    .interrupt                       (intr)
  );

  // Record what the DUT must show after the next observation point.
  task automatic expectNext(input string tag, input logic [7:0] expIrr,
                            input logic [7:0] expInt);
    tagQ.push_back(tag);
    expIrrQ.push_back(expIrr);
    expIntQ.push_back(expInt);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput();
    string      tag;
    logic [7:0] eIrr;
    logic [7:0] eInt;
    if (tagQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    tag  = tagQ.pop_front();
    eIrr = expIrrQ.pop_front();
    eInt = expIntQ.pop_front();
    checks++;
    assert (irr === eIrr) else begin
      failures++;
      $error("[TB] FAIL %s irr observed=%h expected=%h", tag, irr, eIrr);
    end
    checks++;
    assert (intr === eInt) else begin
      failures++;
      $error("[TB] FAIL %s interrupt observed=%h expected=%h", tag, intr, eInt);
    end
  endtask

  // Current inputs are held through one rising edge, then checked.
  task automatic applyStimulus(input string tag, input logic [7:0] expIrr,
                               input logic [7:0] expInt);
    expectNext(tag, expIrr, expInt);
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    reset_n = 1'b0;
    pin     = 8'h00;
    icw1    = 1'b0;
    ltim    = 1'b0;
    freeze  = 1'b0;
    clr     = 8'h00;
    mask    = 8'h00;
    smask   = 8'h00;
    isr     = 8'h00;
    rot     = 3'd7;

    @(negedge clock);
    expectNext("reset", 8'h00, 8'h00);
    checkOutput();
    reset_n = 1'b1;
    applyStimulus("idle", 8'h00, 8'h00);

    // Edge mode: IR3 rises, propagates, then withdraws.
    pin = 8'h08;
    applyStimulus("e_ir3_irr", 8'h08, 8'h00);
    applyStimulus("e_ir3_int", 8'h08, 8'h08);
    pin = 8'h00;
    applyStimulus("e_ir3_drop", 8'h00, 8'h08);
    applyStimulus("e_ir3_idle", 8'h00, 8'h00);

    // Level mode: IR5 held high, one-cycle clear then re-set.
    ltim = 1'b1;
    pin  = 8'h20;
    applyStimulus("l_ir5_irr", 8'h20, 8'h00);
    applyStimulus("l_ir5_int", 8'h20, 8'h20);
    clr = 8'h20;
    applyStimulus("l_ir5_clr", 8'h00, 8'h20);
    clr = 8'h00;
    applyStimulus("l_ir5_reset", 8'h20, 8'h00);
    applyStimulus("l_ir5_int2", 8'h20, 8'h20);
    pin = 8'h00;
    applyStimulus("l_ir5_drop", 8'h00, 8'h20);
    applyStimulus("l_idle", 8'h00, 8'h00);
    ltim = 1'b0;

    // Rotation: IR1 and IR6 together.
    pin = 8'h42;
    applyStimulus("rot_irr", 8'h42, 8'h00);
    applyStimulus("rot7", 8'h42, 8'h02);
    rot = 3'd2;
    applyStimulus("rot2", 8'h42, 8'h40);
    rot = 3'd7;
    pin = 8'h00;
    applyStimulus("rot_drop", 8'h00, 8'h02);
    applyStimulus("rot_idle", 8'h00, 8'h00);

    // Nesting, special mask and IMR.
    isr = 8'h04;
    pin = 8'h10;
    applyStimulus("isr_irr", 8'h10, 8'h00);
    applyStimulus("isr_block", 8'h10, 8'h00);
    smask = 8'h04;
    applyStimulus("smask_pass", 8'h10, 8'h10);
    mask = 8'h10;
    applyStimulus("imr_block", 8'h10, 8'h00);
    mask  = 8'h00;
    smask = 8'h00;
    isr   = 8'h20;
    applyStimulus("isr_lower", 8'h10, 8'h10);
    pin = 8'h00;
    isr = 8'h00;
    applyStimulus("isr_drop", 8'h00, 8'h10);
    applyStimulus("isr_idle", 8'h00, 8'h00);

    // Freeze: edge during freeze is lost.
    freeze = 1'b1;
    pin    = 8'h04;
    applyStimulus("frz_edge", 8'h00, 8'h00);
    freeze = 1'b0;
    applyStimulus("frz_lost", 8'h00, 8'h00);
    pin = 8'h00;
    applyStimulus("frz_low", 8'h00, 8'h00);
    pin = 8'h04;
    applyStimulus("frz_new_irr", 8'h04, 8'h00);
    applyStimulus("frz_new_int", 8'h04, 8'h04);
    freeze = 1'b1;
    pin    = 8'h00;
    applyStimulus("frz_hold", 8'h04, 8'h04);
    clr = 8'h04;
    applyStimulus("frz_clr", 8'h00, 8'h04);
    clr    = 8'h00;
    freeze = 1'b0;
    applyStimulus("frz_idle", 8'h00, 8'h00);

    // ICW1 with IR0 already high.
    pin = 8'h01;
    applyStimulus("icw_irr", 8'h01, 8'h00);
    applyStimulus("icw_int", 8'h01, 8'h01);
    icw1 = 1'b1;
    applyStimulus("icw_clear", 8'h00, 8'h01);
    icw1 = 1'b0;
    applyStimulus("icw_noset", 8'h00, 8'h00);
    applyStimulus("icw_noset2", 8'h00, 8'h00);
    pin = 8'h00;
    applyStimulus("icw_low", 8'h00, 8'h00);
    pin = 8'h01;
    applyStimulus("icw_rearm", 8'h01, 8'h00);
    applyStimulus("icw_rearm_int", 8'h01, 8'h01);

    // Asynchronous reset mid-request.
    reset_n = 1'b0;
    #1;
    expectNext("async_reset", 8'h00, 8'h00);
    checkOutput();
    @(negedge clock);
    reset_n = 1'b1;
    pin     = 8'h00;
    applyStimulus("post_reset", 8'h00, 8'h00);

    // All eight requests, rotate=7 then wrap with rotate=6.
    pin = 8'hFF;
    applyStimulus("all_irr", 8'hFF, 8'h00);
    applyStimulus("all_rot7", 8'hFF, 8'h01);
    rot = 3'd6;
    applyStimulus("all_rot6", 8'hFF, 8'h80);
    pin = 8'h00;
    applyStimulus("all_drop", 8'h00, 8'h80);
    applyStimulus("all_idle", 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pic_interrupt_request_stage
